// File: rtl/apb_accum_pkg.sv
// apb_accum_pkg: shared types and register map for apb_accum_multi.
// Holds ALU opcodes, engine states and CTRL/STATUS bit positions.
package apb_accum_pkg;

    typedef enum logic [1:0] {
        OP_OR  = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_ADD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        COMPUTE   = 2'b01,
        WRITEBACK = 2'b10
    } eng_state_e;

    localparam logic [3:0] OFS_DATA   = 4'h0;
    localparam logic [3:0] OFS_CTRL   = 4'h4;
    localparam logic [3:0] OFS_RESULT = 4'h8;
    localparam logic [3:0] OFS_STATUS = 4'hC;

    localparam int CTRL_START  = 0;
    localparam int CTRL_OP_LO  = 1;
    localparam int CTRL_OP_HI  = 2;
    localparam int CTRL_LOAD   = 3;
    localparam int CTRL_IRQ_EN = 4;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_accum_engine.sv
// apb_accum_engine: shared multi-cycle ALU serving all accumulator channels.
// Lowest-index pending channel wins; operands are snapshotted at issue.
module apb_accum_engine
    import apb_accum_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 32,
    parameter int OP_LATENCY = 4,
    localparam int CH_W      = idx_w(NUM_CH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             busy_i,
    input  logic [NUM_CH-1:0][DATA_W-1:0] data_i,
    input  logic [NUM_CH-1:0][DATA_W-1:0] result_i,
    input  logic [NUM_CH-1:0][1:0]        op_i,
    input  logic [NUM_CH-1:0]             load_i,
    output logic                          wb_valid_o,
    output logic [CH_W-1:0]               wb_ch_o,
    output logic [DATA_W-1:0]             wb_val_o
);

    localparam int CNT_W = idx_w(OP_LATENCY);

    eng_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]   ch_q, ch_d, sel;
    logic [DATA_W-1:0] opnd_q, opnd_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] alu;
    op_e               op_q, op_d;
    logic              load_q, load_d;

    always_comb begin
        sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (busy_i[i]) sel = CH_W'(i);
        end
    end

    // RESULT cannot change while its channel is busy, so snapshotting it is safe
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ch_d       = ch_q;
        opnd_d     = opnd_q;
        acc_d      = acc_q;
        op_d       = op_q;
        load_d     = load_q;
        wb_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|busy_i) begin
                    ch_d    = sel;
                    opnd_d  = data_i[sel];
                    acc_d   = result_i[sel];
                    op_d    = op_e'(op_i[sel]);
                    load_d  = load_i[sel];
                    cnt_d   = CNT_W'(OP_LATENCY - 1);
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (cnt_q == '0) state_d = WRITEBACK;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            WRITEBACK: begin
                wb_valid_o = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu = '0;
        unique case (op_q)
            OP_OR:  alu = acc_q | opnd_q;
            OP_AND: alu = acc_q & opnd_q;
            OP_XOR: alu = acc_q ^ opnd_q;
            OP_ADD: alu = acc_q + opnd_q;
        endcase
    end

    assign wb_ch_o  = ch_q;
    assign wb_val_o = load_q ? opnd_q : alu;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ch_q    <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            op_q    <= OP_OR;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            load_q  <= load_d;
        end
    end

endmodule

// File: rtl/apb_accum_multi.sv
// apb_accum_multi: NUM_CH APB accumulator channels sharing one ALU engine.
// Define APB_ACCUM_IRQ_EN to add the irq output and CTRL.IRQ_EN bit.
module apb_accum_multi
    import apb_accum_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 32,
    parameter int OP_LATENCY = 4,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
`ifdef APB_ACCUM_IRQ_EN
    output logic              pslverr,
    output logic              irq
`else
    output logic              pslverr
`endif
);

    localparam int CH_W = idx_w(NUM_CH);

    logic [NUM_CH-1:0][DATA_W-1:0] data_q, data_d;
    logic [NUM_CH-1:0][DATA_W-1:0] result_q, result_d;
    logic [NUM_CH-1:0][1:0]        op_q, op_d;
    logic [NUM_CH-1:0]             load_q, load_d;
    logic [NUM_CH-1:0]             busy_q, busy_d;
    logic [NUM_CH-1:0]             done_q, done_d;
`ifdef APB_ACCUM_IRQ_EN
    logic [NUM_CH-1:0]             irqen_q, irqen_d;
    logic                          irq_q;
`endif

    logic [ADDR_W-5:0] ch_raw;
    logic [CH_W-1:0]   ch;
    logic [3:0]        ofs;
    logic              ch_ok, access, err, stall, xfer, wr_en, rd_en;
    logic              is_data, is_ctrl, is_res, is_stat;
    logic              irqen_rd;
    logic [31:0]       ctrl_rd, rdata;
    logic              wb_valid;
    logic [CH_W-1:0]   wb_ch;
    logic [DATA_W-1:0] wb_val;
    logic              unused_bits;

    assign ch_raw  = paddr[ADDR_W-1:4];
    assign ch      = ch_raw[CH_W-1:0];
    assign ch_ok   = 32'(ch_raw) < 32'(NUM_CH);
    assign ofs     = {paddr[3:2], 2'b00};
    assign is_data = ofs == OFS_DATA;
    assign is_ctrl = ofs == OFS_CTRL;
    assign is_res  = ofs == OFS_RESULT;
    assign is_stat = ofs == OFS_STATUS;

    assign unused_bits = ^{paddr[1:0], pwdata};

    // Outputs are forced idle while reset is held
    assign access = psel & penable & ~reset;
    assign err    = ~ch_ok
                  | (pwrite & (is_res | is_stat))
                  | (pwrite & is_ctrl & pwdata[CTRL_START] & busy_q[ch]);
    assign stall  = ch_ok & ~pwrite & is_res & busy_q[ch];
    assign xfer   = access & ~stall;
    assign wr_en  = xfer & pwrite & ~err;
    assign rd_en  = xfer & ~pwrite & ~err;

    assign pready  = xfer;
    assign pslverr = access & err;
    assign prdata  = rd_en ? rdata : 32'h0;

`ifdef APB_ACCUM_IRQ_EN
    assign irqen_rd = irqen_q[ch];
    assign irq      = irq_q;
`else
    assign irqen_rd = 1'b0;
`endif

    assign ctrl_rd = {27'b0, irqen_rd, load_q[ch], op_q[ch], 1'b0};

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            is_data: rdata = 32'(data_q[ch]);
            is_ctrl: rdata = ctrl_rd;
            is_res:  rdata = 32'(result_q[ch]);
            is_stat: rdata = 32'({done_q[ch], busy_q[ch]});
            default: rdata = '0;
        endcase
    end

    always_comb begin
        data_d   = data_q;
        result_d = result_q;
        op_d     = op_q;
        load_d   = load_q;
        busy_d   = busy_q;
        done_d   = done_q;
`ifdef APB_ACCUM_IRQ_EN
        irqen_d  = irqen_q;
`endif
        if (wr_en && is_data) data_d[ch] = pwdata[DATA_W-1:0];
        if (rd_en && is_stat) done_d[ch] = 1'b0;
        if (wr_en && is_ctrl) begin
            op_d[ch]   = pwdata[CTRL_OP_HI:CTRL_OP_LO];
            load_d[ch] = pwdata[CTRL_LOAD];
`ifdef APB_ACCUM_IRQ_EN
            irqen_d[ch] = pwdata[CTRL_IRQ_EN];
`endif
            if (pwdata[CTRL_START]) begin
                busy_d[ch] = 1'b1;
                done_d[ch] = 1'b0;
            end
        end
        if (wb_valid) begin
            result_d[wb_ch] = wb_val;
            busy_d[wb_ch]   = 1'b0;
            done_d[wb_ch]   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q   <= '0;
            result_q <= '0;
            op_q     <= '0;
            load_q   <= '0;
            busy_q   <= '0;
            done_q   <= '0;
        end else begin
            data_q   <= data_d;
            result_q <= result_d;
            op_q     <= op_d;
            load_q   <= load_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef APB_ACCUM_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqen_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            irqen_q <= irqen_d;
            irq_q   <= |(done_q & irqen_q);
        end
    end
`endif

    apb_accum_engine #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .OP_LATENCY (OP_LATENCY)
    ) u_engine (
        .clk        (clk),
        .reset      (reset),
        .busy_i     (busy_q),
        .data_i     (data_q),
        .result_i   (result_q),
        .op_i       (op_q),
        .load_i     (load_q),
        .wb_valid_o (wb_valid),
        .wb_ch_o    (wb_ch),
        .wb_val_o   (wb_val)
    );

endmodule

// File: tb/tb_apb_accum_multi.sv
// tb_apb_accum_multi: directed vector table plus multi-cycle sequences.
// Build with APB_ACCUM_IRQ_EN defined to also exercise the irq output.
module tb_apb_accum_multi;

    localparam int NUM_CH     = 4;
    localparam int DATA_W     = 32;
    localparam int OP_LATENCY = 4;
    localparam int ADDR_W     = 8;

`ifdef APB_ACCUM_IRQ_EN
    localparam logic [31:0] CTRL_RB = 32'h16;
`else
    localparam logic [31:0] CTRL_RB = 32'h06;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              psel = 1'b0;
    logic              penable = 1'b0;
    logic              pwrite = 1'b0;
    logic [ADDR_W-1:0] paddr = '0;
    logic [31:0]       pwdata = '0;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;
`ifdef APB_ACCUM_IRQ_EN
    logic              irq;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] r_data;
    logic        r_err;
    int          r_waits;
    int          r_rdy;
    int          r_end;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_accum_multi #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .OP_LATENCY (OP_LATENCY),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
`ifdef APB_ACCUM_IRQ_EN
        .pslverr (pslverr),
        .irq     (irq)
`else
        .pslverr (pslverr)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the completing edge
    task automatic xfer(input logic wr, input logic [7:0] a,
                        input logic [31:0] wd);
        psel = 1'b1;
        penable = 1'b0;
        pwrite = wr;
        paddr = a;
        pwdata = wd;
        @(posedge clk);
        #1 penable = 1'b1;
        #1;
        r_waits = 0;
        while (!pready && r_waits < 100) begin
            @(posedge clk);
            #2;
            r_waits++;
        end
        r_rdy = cyc;
        if (!pready) begin
            checks++;
            failures++;
            $display("FAIL timeout addr=0x%02h actual=no_pready required=pready", a);
        end
        r_data = prdata;
        r_err = pslverr;
        @(posedge clk);
        #1;
        r_end = cyc;
        psel = 1'b0;
        penable = 1'b0;
        pwrite = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt[13];
    int   t_start;
    int   t_ch3;

    initial begin
        vt[0]  = '{1'b0, 8'h00, 32'h0, 32'h0, 1'b0};
        vt[1]  = '{1'b0, 8'h04, 32'h0, 32'h0, 1'b0};
        vt[2]  = '{1'b0, 8'h08, 32'h0, 32'h0, 1'b0};
        vt[3]  = '{1'b0, 8'h0C, 32'h0, 32'h0, 1'b0};
        vt[4]  = '{1'b1, 8'h40, 32'h12345678, 32'h0, 1'b1};
        vt[5]  = '{1'b1, 8'h08, 32'h12345678, 32'h0, 1'b1};
        vt[6]  = '{1'b0, 8'h40, 32'h0, 32'h0, 1'b1};
        vt[7]  = '{1'b0, 8'h08, 32'h0, 32'h0, 1'b0};
        vt[8]  = '{1'b1, 8'h00, 32'hA5A5A5A5, 32'h0, 1'b0};
        vt[9]  = '{1'b0, 8'h00, 32'h0, 32'hA5A5A5A5, 1'b0};
        vt[10] = '{1'b1, 8'h04, 32'h00000016, 32'h0, 1'b0};
        vt[11] = '{1'b0, 8'h04, 32'h0, CTRL_RB, 1'b0};
        vt[12] = '{1'b1, 8'h04, 32'h0, 32'h0, 1'b0};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_pready_idle", 32'(pready), 32'h0);
`ifdef APB_ACCUM_IRQ_EN
        chk("rst_irq", 32'(irq), 32'h0);
`endif

        for (int i = 0; i < 13; i++) begin
            xfer(vt[i].wr, vt[i].addr, vt[i].wdata);
            if (!vt[i].wr)
                chk($sformatf("vec%0d_rdata", i), r_data, vt[i].exp_rd);
            chk($sformatf("vec%0d_pslverr", i), 32'(r_err), 32'(vt[i].exp_err));
            chk($sformatf("vec%0d_waits", i), r_waits, 0);
        end

        // ch1 OR accumulate, with a DATA write during the second compute
        xfer(1'b1, 8'h10, 32'h0000000F);
        xfer(1'b1, 8'h14, 32'h1);
        t_start = r_end;
        xfer(1'b0, 8'h18, 32'h0);
        chk("ch1_or1_result", r_data, 32'h0000000F);
        chk("ch1_or1_lat", r_rdy - t_start, OP_LATENCY + 2);
        xfer(1'b1, 8'h10, 32'h000000F0);
        xfer(1'b1, 8'h14, 32'h1);
        t_start = r_end;
        xfer(1'b1, 8'h10, 32'h00000100);
        xfer(1'b0, 8'h18, 32'h0);
        chk("ch1_or2_result", r_data, 32'h000000FF);
        chk("ch1_or2_lat", r_rdy - t_start, OP_LATENCY + 2);
        chk("ch1_or2_err", 32'(r_err), 32'h0);
        xfer(1'b0, 8'h1C, 32'h0);
        chk("ch1_status_done", r_data, 32'h2);
        xfer(1'b0, 8'h1C, 32'h0);
        chk("ch1_status_clr", r_data, 32'h0);

        // ch2 LOAD then wrapping ADD
        xfer(1'b1, 8'h20, 32'hFFFFFFFF);
        xfer(1'b1, 8'h24, 32'h9);
        xfer(1'b0, 8'h28, 32'h0);
        chk("ch2_load", r_data, 32'hFFFFFFFF);
        xfer(1'b1, 8'h20, 32'h00000001);
        xfer(1'b1, 8'h24, 32'h7);
        xfer(1'b0, 8'h28, 32'h0);
        chk("ch2_add_wrap", r_data, 32'h0);

        // ch3 then ch0 queued; busy START on ch3 rejected
        xfer(1'b1, 8'h30, 32'h00000003);
        xfer(1'b1, 8'h00, 32'h00000005);
        xfer(1'b1, 8'h34, 32'h9);
        t_ch3 = r_end;
        xfer(1'b1, 8'h04, 32'h9);
        xfer(1'b1, 8'h34, 32'h1);
        chk("ch3_busy_start_err", 32'(r_err), 32'h1);
        xfer(1'b0, 8'h08, 32'h0);
        chk("ch0_queued_result", r_data, 32'h5);
        chk("ch0_queued_lat", r_rdy - t_ch3, 2 * (OP_LATENCY + 2));
        xfer(1'b0, 8'h38, 32'h0);
        chk("ch3_result", r_data, 32'h3);
        xfer(1'b0, 8'h34, 32'h0);
        chk("ch3_ctrl_kept", r_data, 32'h8);
        xfer(1'b0, 8'h3C, 32'h0);
        chk("ch3_status", r_data, 32'h2);

        // reset during ch1 compute discards the operation
        xfer(1'b1, 8'h10, 32'h00000055);
        xfer(1'b1, 8'h14, 32'h9);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        psel = 1'b1;
        penable = 1'b1;
        paddr = 8'h1C;
        #1;
        chk("rst_pready", 32'(pready), 32'h0);
        chk("rst_pslverr", 32'(pslverr), 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        psel = 1'b0;
        penable = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        xfer(1'b0, 8'h1C, 32'h0);
        chk("post_rst_status", r_data, 32'h0);
        xfer(1'b0, 8'h18, 32'h0);
        chk("post_rst_result", r_data, 32'h0);
        xfer(1'b0, 8'h10, 32'h0);
        chk("post_rst_data", r_data, 32'h0);

`ifdef APB_ACCUM_IRQ_EN
        chk("irq_after_rst", 32'(irq), 32'h0);
        xfer(1'b1, 8'h00, 32'h00000077);
        xfer(1'b1, 8'h04, 32'h19);
        repeat (OP_LATENCY + 4) @(posedge clk);
        #1;
        chk("irq_rise", 32'(irq), 32'h1);
        xfer(1'b0, 8'h0C, 32'h0);
        chk("irq_status", r_data, 32'h2);
        chk("irq_hold", 32'(irq), 32'h1);
        @(posedge clk);
        #1;
        chk("irq_fall", 32'(irq), 32'h0);
        xfer(1'b0, 8'h08, 32'h0);
        chk("irq_result", r_data, 32'h77);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
